// File: rtl/serial_add_sub_pkg.sv
// Shared constants and state encoding for the bit-serial adder/subtractor.
package serial_add_sub_pkg;
  localparam int DATA_WIDTH = 32;

  localparam logic SADD_OP_ADD = 1'b0;
  localparam logic SADD_OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } sadd_state_e;
endpackage

// File: rtl/serial_add_sub_if.sv
// START/DONE handshake and operand/result bundle between sequencer and serial adder.
interface serial_add_sub_if #(parameter int WIDTH = serial_add_sub_pkg::DATA_WIDTH);
  logic             START;
  logic             OP;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] S;
  logic             CO;
  logic             V;
  logic             Z;

  modport master (output START, OP, A, B, input BUSY, DONE, S, CO, V, Z);
  modport slave  (input START, OP, A, B, output BUSY, DONE, S, CO, V, Z);
endinterface

// File: rtl/serial_add_sub_fa.sv
// Single-bit full adder; the only arithmetic element in the serial datapath.
module serial_add_sub_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract: one operand bit pair per clock through a single full adder,
// WIDTH cycles in RUN, then a one-cycle DONE with S/CO/V/Z updated.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic           CLK,
  input  logic           RST,
  serial_add_sub_if.slave bus
);
  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   PENU = CW'(WIDTH - 2);

  sadd_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, res_q, res_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d, v_q, v_d, z_q, z_d;
  logic             fa_s, fa_co;

  serial_add_sub_fa u_fa (
    .a  (sa_q[0]),
    .b  (sb_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    s_d     = s_q;
    co_d    = co_q;
    v_d     = v_q;
    z_d     = z_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.START) begin
          // Subtract as A + ~B + 1: the +1 enters through the initial carry.
          state_d = ST_RUN;
          sa_d    = bus.A;
          sb_d    = (bus.OP == SADD_OP_SUB) ? ~bus.B : bus.B;
          carry_d = bus.OP;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == PENU) cmsb_d = fa_co;
        if (cnt_q == LAST) begin
          s_d     = res_d;
          co_d    = fa_co;
          v_d     = cmsb_q ^ fa_co;
          z_d     = ~|res_d;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      s_q     <= s_d;
      co_q    <= co_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  assign bus.BUSY = (state_q == ST_RUN);
  assign bus.DONE = (state_q == ST_DONE);
  assign bus.S    = s_q;
  assign bus.CO   = co_q;
  assign bus.V    = v_q;
  assign bus.Z    = z_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// Randomized and directed bench for serial_add_sub against a plain-arithmetic model.
module tb_serial_add_sub;
  localparam int W = 32;

  logic   CLK = 1'b0;
  logic   RST;
  int     n_chk  = 0;
  int     n_pass = 0;
  longint cyc    = 0;

  serial_add_sub_if #(.WIDTH(W)) bus ();
  serial_add_sub #(.WIDTH(W)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: unsigned carry/borrow and signed overflow from wide integer arithmetic.
  function automatic void model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] s, output logic co, output logic v,
                                output logic z);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint r;
    longint smax = (longint'(1) <<< (W - 1)) - 1;
    longint smin = -(longint'(1) <<< (W - 1));
    if (op) begin
      s  = a - b;
      co = (ua >= ub);
      r  = sa - sb;
    end else begin
      s  = a + b;
      co = ((ua + ub) >= (longint'(1) <<< W));
      r  = sa + sb;
    end
    v = (r > smax) || (r < smin);
    z = (s == '0);
  endfunction

  task automatic launch(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLK);
    bus.START = 1'b1; bus.OP = op; bus.A = a; bus.B = b;
    @(negedge CLK);
    bus.START = 1'b0; bus.OP = 1'($urandom); bus.A = $urandom; bus.B = $urandom;
  endtask

  // Counts BUSY negedges until DONE appears; bounded.
  task automatic wait_done(output int busy_n, output bit got);
    busy_n = 0; got = 1'b0;
    for (int i = 0; i < W + 10; i++) begin
      if (bus.DONE) begin got = 1'b1; break; end
      if (bus.BUSY) busy_n++;
      @(negedge CLK);
    end
  endtask

  task automatic chk_res(input string tag, input logic op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    logic [W-1:0] es; logic eco, ev, ez;
    model(op, a, b, es, eco, ev, ez);
    chk({tag, ".S"},  64'(bus.S),  64'(es));
    chk({tag, ".CO"}, 64'(bus.CO), 64'(eco));
    chk({tag, ".V"},  64'(bus.V),  64'(ev));
    chk({tag, ".Z"},  64'(bus.Z),  64'(ez));
  endtask

  task automatic do_op(input string tag, input logic op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    int bn; bit got; logic [W-1:0] held;
    launch(op, a, b);
    wait_done(bn, got);
    chk({tag, ".done"}, 64'(got), 64'(1));
    chk({tag, ".busy_cycles"}, 64'(bn), 64'(W));
    chk({tag, ".busy_at_done"}, 64'(bus.BUSY), 64'(0));
    chk_res(tag, op, a, b);
    held = bus.S;
    @(negedge CLK);
    chk({tag, ".done_pulse"}, 64'(bus.DONE), 64'(0));
    repeat (2) @(negedge CLK);
    chk({tag, ".hold"}, 64'(bus.S), 64'(held));
  endtask

  initial begin
    int bn; bit got; bit seen; longint t1;
    logic [W-1:0] a0, b0;
    bus.START = 1'b0; bus.OP = 1'b0; bus.A = '0; bus.B = '0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst.BUSY", 64'(bus.BUSY), 64'(0));
    chk("rst.DONE", 64'(bus.DONE), 64'(0));
    chk("rst.S",    64'(bus.S),    64'(0));
    chk("rst.CO",   64'(bus.CO),   64'(0));
    chk("rst.V",    64'(bus.V),    64'(0));
    chk("rst.Z",    64'(bus.Z),    64'(0));
    RST = 1'b0;

    do_op("add5_3",   1'b0, 32'd5,          32'd3);
    do_op("add_ovf",  1'b0, 32'h7FFF_FFFF,  32'h1);
    do_op("add_wrap", 1'b0, 32'hFFFF_FFFF,  32'h1);
    do_op("sub5_7",   1'b1, 32'd5,          32'd7);
    do_op("sub_ovf",  1'b1, 32'h8000_0000,  32'h1);
    do_op("sub_eq",   1'b1, 32'h1234_5678,  32'h1234_5678);

    // START and operand changes mid-RUN are ignored.
    a0 = 32'h1234_5678; b0 = 32'h0000_1111;
    launch(1'b0, a0, b0);
    repeat (9) @(negedge CLK);
    bus.START = 1'b1; bus.OP = 1'b1; bus.A = $urandom; bus.B = $urandom;
    @(negedge CLK);
    bus.START = 1'b0;
    wait_done(bn, got);
    chk("ignore.done", 64'(got), 64'(1));
    chk_res("ignore", 1'b0, a0, b0);
    @(negedge CLK);

    // Reset mid-RUN aborts with no DONE.
    launch(1'b0, 32'hAAAA_0000, 32'h0000_5555);
    repeat (9) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("abort.BUSY", 64'(bus.BUSY), 64'(0));
    chk("abort.S",    64'(bus.S),    64'(0));
    chk("abort.CO",   64'(bus.CO),   64'(0));
    @(negedge CLK);
    RST = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge CLK);
      if (bus.DONE || bus.BUSY) seen = 1'b1;
    end
    chk("abort.no_done", 64'(seen), 64'(0));
    do_op("post_rst", 1'b0, 32'd1, 32'd1);

    // Back-to-back: START held through DONE.
    a0 = $urandom; b0 = $urandom;
    launch(1'b1, 32'd100, 32'd42);
    wait_done(bn, got);
    chk("b2b.first", 64'(got), 64'(1));
    t1 = cyc;
    bus.START = 1'b1; bus.OP = 1'b0; bus.A = a0; bus.B = b0;
    chk_res("b2b1", 1'b1, 32'd100, 32'd42);
    @(negedge CLK);
    bus.START = 1'b0; bus.A = $urandom; bus.B = $urandom;
    chk("b2b.rerun", 64'(bus.BUSY), 64'(1));
    wait_done(bn, got);
    chk("b2b.second", 64'(got), 64'(1));
    chk("b2b.spacing", 64'(cyc - t1), 64'(W + 1));
    chk_res("b2b2", 1'b0, a0, b0);
    @(negedge CLK);

    for (int k = 0; k < 24; k++) begin
      logic [W-1:0] ra, rb; logic rop;
      ra = $urandom; rb = $urandom; rop = 1'($urandom);
      if (k % 6 == 0) rb = ra;
      if (k % 6 == 1) ra = 32'h8000_0000;
      do_op($sformatf("rnd%0d", k), rop, ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Bit-serial adder/subtractor that feeds one FULL_ADDER instance with one operand bit pair per clock.
- Registers the carry-out between cycles and shifts sum bits into a result register.
- A low-area alternative to the ripple-carry adder, for multi-cycle ALU operations.
- Presents a START/DONE handshake to the ALU control sequencer upstream.

Parameters:
- WIDTH, 32 (`DATA_WIDTH), operand and result width in bits; must be >= 2.

Ports:
- CLK     input   1      system clock, rising edge
- RST     input   1      asynchronous active-high reset
- START   input   1      request; sampled only in IDLE or DONE
- OP      input   1      0 = add (A+B), 1 = subtract (A-B); sampled with START
- A       input   WIDTH  operand A; sampled with START
- B       input   WIDTH  operand B; sampled with START
- BUSY    output  1      high while in RUN
- DONE    output  1      one-cycle pulse; result valid
- S       output  WIDTH  result, held until next DONE
- CO      output  1      carry out; for subtract, 1 = no borrow (A >= B unsigned)
- V       output  1      signed overflow
- Z       output  1      1 when S == 0

Behaviour:
- One clock, CLK. RST is asynchronous and active-high.
- While RST is high: state = IDLE, bit counter = 0, carry register = 0, BUSY = 0, DONE = 0, S = 0, CO = 0, V = 0, Z = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, START = 1 at edge t0:
  - Load shift register SA <= A.
  - Load shift register SB <= (OP ? ~B : B).
  - Carry register <= OP (two's-complement +1).
  - Counter <= 0; go to RUN.
- IDLE, START = 0: stay in IDLE.
- RUN, every edge:
  - FULL_ADDER inputs are A = SA[0], B = SB[0], CI = carry register.
  - Sum bit shifts into the MSB of the working result; SA and SB shift right.
  - Carry register <= adder CO. Counter increments.
  - On the edge processing bit WIDTH-2, capture the carry register value (carry into the MSB) as c_msb_in.
- RUN, edge where counter == WIDTH-1 (edge t0+WIDTH):
  - The last bit is processed.
  - Update S = final working result, CO = final carry, V = c_msb_in XOR final carry, Z = (final S == 0).
  - Go to DONE.
- DONE: DONE = 1 for exactly one cycle. The next edge goes to IDLE, or to RUN if START = 1 (back-to-back accepted).
- Latency: DONE is high in the cycle following edge t0+WIDTH, so back-to-back throughput is one operation per WIDTH+1 cycles.
- BUSY = 1 exactly in RUN, i.e. WIDTH cycles.
- START during RUN is ignored: no queuing, no restart, operands are not resampled.
- Changes on A, B, or OP after the sampling edge have no effect on the result.
- S, CO, V, and Z change only on the DONE-entry edge or on reset. They hold their values through IDLE and the next RUN.
- Reset asserted mid-RUN: the operation is aborted immediately, all outputs are cleared, and no DONE pulse is issued.
- Arithmetic is modulo 2^WIDTH; operands are treated as two's complement for V and as unsigned for CO.

Decomposition:
- The following constants are added to prj_definition.v:
  - `DATA_WIDTH
  - `SADD_OP_ADD = 1'b0, `SADD_OP_SUB = 1'b1
  - state encodings `SADD_ST_IDLE = 2'b00, `SADD_ST_RUN = 2'b01, `SADD_ST_DONE = 2'b10
- One sub-module: the existing FULL_ADDER, instantiated once. No other arithmetic is inferred.
- The counter width is the clog2 of WIDTH, computed locally.

Test Plan (WIDTH = 32):
- Add, A = 5, B = 3, START pulsed at t0 -> BUSY high for 32 cycles; DONE high in the cycle after edge t0+32. Result: S = 8, CO = 0, V = 0, Z = 0.
- Add, A = 0x7FFFFFFF, B = 0x00000001 -> S = 0x80000000, CO = 0, V = 1, Z = 0.
- Add, A = 0xFFFFFFFF, B = 0x00000001 -> S = 0, CO = 1, V = 0, Z = 1.
- Sub, A = 5, B = 7 -> S = 0xFFFFFFFE, CO = 0, V = 0.
- Sub, A = 0x80000000, B = 1 -> S = 0x7FFFFFFF, CO = 1, V = 1.
- Control and reset checks:
  - Pulse START again and change A/B at cycle 10 of RUN -> ignored; the original result is delivered.
  - Assert RST at cycle 10 of a second operation -> BUSY = 0 and S = 0 immediately, no DONE.
  - After reset, START with A = 1, B = 1 -> S = 2.
  - START held high during DONE -> re-enters RUN; second DONE arrives 33 cycles after the first.
